// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store memory controller: access sizes,
// controller states, the default response timeout and the alignment rule.
package lsu_mem_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // An access is misaligned when it is not naturally aligned to its own size.
    function automatic logic is_misaligned(input logic [2:0] off, input size_e size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = (off[0] != 1'b0);
            SZ_W:    mis = (off[1:0] != 2'b00);
            SZ_D:    mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads within one aligned 8-byte bus word. Purely combinational.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  off,
    input  size_e       size,
    input  logic        load_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_lane,
    output logic [7:0]  wmask,
    output logic [63:0] load_data
);

    logic [5:0]  shamt_s;
    logic [63:0] rshift_s;

    // Shift store data up to its lane and bring the addressed load lane down to bit 0.
    always_comb begin
        shamt_s    = {off, 3'b000};
        wdata_lane = wdata << shamt_s;
        rshift_s   = rdata >> shamt_s;
        wmask      = 8'hFF;
        load_data  = rdata;
        case (size)
            SZ_B: begin
                wmask     = 8'h01 << off;
                load_data = load_unsigned ? {56'd0, rshift_s[7:0]}
                                          : {{56{rshift_s[7]}}, rshift_s[7:0]};
            end
            SZ_H: begin
                wmask     = 8'h03 << off;
                load_data = load_unsigned ? {48'd0, rshift_s[15:0]}
                                          : {{48{rshift_s[15]}}, rshift_s[15:0]};
            end
            SZ_W: begin
                wmask     = 8'h0F << off;
                load_data = load_unsigned ? {32'd0, rshift_s[31:0]}
                                          : {{32{rshift_s[31]}}, rshift_s[31:0]};
            end
            SZ_D: begin
                wmask     = 8'hFF;
                load_data = rdata;
            end
            default: begin
                wmask     = 8'hFF;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one EXU request, runs a single
// valid/ready bus transaction with a response timeout, and returns to WBU.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_r;
    state_e            state_s;
    logic [XLEN-1:0]   addr_r;
    logic              wen_r;
    size_e             size_r;
    logic              uns_r;
    logic [XLEN-1:0]   wdata_r;
    logic [XLEN-1:0]   rdata_r;
    logic              err_r;
    logic [7:0]        cnt_r;

    logic              req_mis_s;
    logic [XLEN-1:0]   wdata_lane_s;
    logic [7:0]        wmask_s;
    logic [XLEN-1:0]   load_data_s;
    logic [XLEN-1:0]   rsp_data_s;
    logic              timeout_s;

    lsu_lane_align u_align (
        .off           (addr_r[2:0]),
        .size          (size_r),
        .load_unsigned (uns_r),
        .wdata         (wdata_r),
        .rdata         (mem_rdata),
        .wdata_lane    (wdata_lane_s),
        .wmask         (wmask_s),
        .load_data     (load_data_s)
    );

    assign req_mis_s  = is_misaligned(req_addr[2:0], size_e'(req_size));
    assign rsp_data_s = wen_r ? {XLEN{1'b0}} : load_data_s;
    assign timeout_s  = (cnt_r == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = req_mis_s ? ST_RESP : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_s = mem_rsp_valid ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request latch, response capture and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {XLEN{1'b0}};
            wen_r   <= 1'b0;
            size_r  <= SZ_B;
            uns_r   <= 1'b0;
            wdata_r <= {XLEN{1'b0}};
            rdata_r <= {XLEN{1'b0}};
            err_r   <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r  <= req_addr;
                        wen_r   <= req_wen;
                        size_r  <= size_e'(req_size);
                        uns_r   <= req_unsigned;
                        wdata_r <= req_wdata;
                        rdata_r <= {XLEN{1'b0}};
                        err_r   <= req_mis_s;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        cnt_r <= 8'd0;
                        if (mem_rsp_valid) begin
                            rdata_r <= rsp_data_s;
                            err_r   <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_r <= rsp_data_s;
                        err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rdata_r <= {XLEN{1'b0}};
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Outputs come straight from state and latched registers; loads never assert byte enables.
    assign req_ready  = (state_r == ST_IDLE);
    assign mem_valid  = (state_r == ST_REQ);
    assign resp_valid = (state_r == ST_RESP);
    assign mem_addr   = {addr_r[XLEN-1:3], 3'b000};
    assign mem_wen    = wen_r;
    assign mem_wdata  = wdata_lane_s;
    assign mem_wmask  = wen_r ? wmask_s : 8'h00;
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed and randomized bench for lsu_mem_ctrl; expected values come from
// a size/offset arithmetic model of the load/store rules.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_ctrl #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wen       (req_wen),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wdata     (req_wdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; rsp_dly < 0 means the bus never responds.
    task automatic run_txn(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [63:0] wdata, input logic [63:0] rdata,
                           input int rdy_dly, input int rsp_dly, input int resp_dly);
        int          nbytes;
        int          off;
        int          waited;
        logic        mis;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [63:0] v;
        logic [63:0] m;
        nbytes    = 1 << size;
        off       = int'(addr[2:0]);
        mis       = (addr % 64'(nbytes)) != 64'd0;
        exp_mask  = wen ? 8'(((32'd1 << nbytes) - 32'd1) << off) : 8'h00;
        exp_wdata = wdata << (8 * off);
        v = rdata >> (8 * off);
        if (nbytes < 8) begin
            m = (64'd1 << (8 * nbytes)) - 64'd1;
            v = v & m;
            if (!uns && v[8 * nbytes - 1]) v = v | ~m;
        end
        exp_err   = mis || (rsp_dly < 0);
        exp_rdata = (wen || exp_err) ? 64'd0 : v;

        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = addr; req_wen = wen; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        if (!mis) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                if (i == rdy_dly) begin
                    mem_ready = 1'b1;
                    if (rsp_dly == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata     = rdata;
                    end
                end
                chk("req_mem_valid", {63'd0, mem_valid}, 64'd1);
                chk("req_mem_addr", mem_addr, {addr[63:3], 3'b000});
                chk("req_mem_wen", {63'd0, mem_wen}, {63'd0, wen});
                chk("req_mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_mask});
                if (wen) chk("req_mem_wdata", mem_wdata, exp_wdata);
                chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
                step();
            end
            mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
            if (rsp_dly > 0) begin
                for (int i = 1; i <= rsp_dly; i++) begin
                    if (i == rsp_dly) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata     = rdata;
                    end
                    chk("wait_mem_valid", {63'd0, mem_valid}, 64'd0);
                    chk("wait_resp_valid", {63'd0, resp_valid}, 64'd0);
                    step();
                end
                mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
            end else if (rsp_dly < 0) begin
                waited = 0;
                while (resp_valid !== 1'b1 && waited < TIMEOUT + 8) begin
                    step();
                    waited++;
                end
                chk("timeout_cycles", 64'(waited), 64'(TIMEOUT));
            end
        end
        for (int i = 0; i <= resp_dly; i++) begin
            if (i == resp_dly) resp_ready = 1'b1;
            chk("resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
            chk("resp_mem_valid", {63'd0, mem_valid}, 64'd0);
            chk("resp_req_ready", {63'd0, req_ready}, 64'd0);
            step();
        end
        resp_ready = 1'b0;
        chk("post_resp_valid", {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        rst = 1'b0;
        step();

        // Signed byte, unsigned/signed half, word store, misaligned double.
        run_txn(64'h8000_0005, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0000_8000_0000_0000, 0, 1, 0);
        chk("lb_value", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(64'h8000_0006, 1'b0, 2'd1, 1'b1, 64'd0, 64'hBEEF_0000_0000_0000, 0, 1, 0);
        run_txn(64'h8000_0006, 1'b0, 2'd1, 1'b0, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0, 0);
        run_txn(64'h8000_0004, 1'b1, 2'd2, 1'b0, 64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
        run_txn(64'h8000_0002, 1'b0, 2'd3, 1'b0, 64'd0, 64'd0, 0, 1, 0);

        // Stalls on both handshakes, then a timeout.
        run_txn(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'hA5A5_0101_F00D_CAFE, 64'd0, 5, 3, 4);
        run_txn(64'h8000_0018, 1'b0, 2'd2, 1'b0, 64'd0, 64'h0, 0, -1, 1);

        // A late response in IDLE must be ignored.
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        step();
        mem_rsp_valid = 1'b0;
        chk("late_rsp_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("late_rsp_req_ready", {63'd0, req_ready}, 64'd1);

        // A request held across the response handshake is taken one cycle later.
        req_valid = 1'b1; req_addr = 64'h8000_0001; req_wen = 1'b1; req_size = 2'd2;
        req_wdata = 64'h55;
        step();
        chk("b2b_first_resp", {63'd0, resp_valid}, 64'd1);
        chk("b2b_first_err", {63'd0, resp_err}, 64'd1);
        resp_ready = 1'b1; req_addr = 64'h8000_0020; req_wen = 1'b0; req_size = 2'd3;
        step();
        resp_ready = 1'b0;
        chk("b2b_gap_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("b2b_gap_req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk("b2b_accept_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("b2b_accept_mem_addr", mem_addr, 64'h8000_0020);
        mem_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
        step();
        mem_ready = 1'b0; mem_rsp_valid = 1'b0;
        chk("b2b_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("b2b_resp_rdata", resp_rdata, 64'hDEAD_BEEF_0123_4567);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset while waiting for the bus response.
        req_valid = 1'b1; req_addr = 64'h8000_0028; req_wen = 1'b0; req_size = 2'd3;
        step();
        req_valid = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("wait_before_rst", {63'd0, mem_valid}, 64'd0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_wait_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_wait_resp_valid", {63'd0, resp_valid}, 64'd0);
        step();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [63:0] a;
            a = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            run_txn(a, 1'($urandom), 2'($urandom), 1'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Responder side of the address/data path the ALU drives: accepts one load/store request per transaction from EXU.
- Request address is the ALU add result (base + imm).
- Performs alignment checking, byte-lane steering, write-mask generation, a valid/ready memory-bus transaction with timeout, and load sign/zero extension.
- Returns the result to WBU through a response handshake.
- Sits between EXU/WBU and the data-memory bus (DPI RAM or AXI-lite bridge).

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TIMEOUT, 255, max cycles waiting for mem_rsp_valid before flagging a bus error; 8-bit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  EXU request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  64  byte address.
- req_wen  in  1  1=store, 0=load.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_unsigned  in  1  load zero-extend (lbu/lhu/lwu); ignored for stores and D.
- req_wdata  in  64  store data, LSB-aligned.
- mem_valid  out  1  bus request valid.
- mem_ready  in  1  bus accepts request.
- mem_addr  out  64  req_addr with [2:0] forced to 0.
- mem_wen  out  1  write request.
- mem_wdata  out  64  store data shifted to byte lane.
- mem_wmask  out  8  byte enables; 0 for loads.
- mem_rsp_valid  in  1  bus response (read data or write ack).
- mem_rdata  in  64  aligned 8-byte read data.
- resp_valid  out  1  result to WBU.
- resp_ready  in  1  WBU accepts.
- resp_rdata  out  64  extended load data; 0 for stores.
- resp_err  out  1  misaligned or timeout.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; timeout counter 0; internal request latch 0.
- IDLE: req_ready=1. On req_valid, latch addr/wen/size/unsigned/wdata.
  - Aligned: go to REQ.
  - Misaligned: go to RESP with resp_err=1, resp_rdata=0, and no bus activity.
  - Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0.
- REQ: mem_valid=1, with mem_addr/mem_wen/mem_wdata/mem_wmask held stable from the latch.
  - On mem_ready, go to WAIT and clear the counter.
  - If mem_ready and mem_rsp_valid are high in the same cycle, capture the response and go directly to RESP.
- WAIT: counter increments each cycle.
  - On mem_rsp_valid: capture mem_rdata, go to RESP, resp_err=0.
  - If the counter reaches TIMEOUT with no response: go to RESP with resp_err=1, resp_rdata=0.
  - A late mem_rsp_valid arriving in IDLE is ignored.
- RESP: resp_valid=1, with resp_rdata/resp_err held stable until resp_ready, then IDLE.
  - Back-to-back requests are accepted in the cycle after the RESP handshake, never in the same cycle.
- Lane steering: off = addr[2:0].
  - mem_wdata = req_wdata << (8*off).
  - mem_wmask: B 8'b1<<off; H 8'b11<<off; W 8'hF<<off; D 8'hFF.
- Load extraction: r = mem_rdata >> (8*off), truncated to the size.
  - Sign-extended from bit 7/15/31 unless req_unsigned=1.
  - D is passed unchanged.
- Minimum latency, request accepted to resp_valid:
  - 1 cycle for a misaligned request (IDLE→RESP).
  - 2 cycles if mem_ready and mem_rsp_valid come in the same cycle.
  - 3 cycles with a 1-cycle memory.
- rst asserted in any state returns to IDLE on the next edge and drops mem_valid/resp_valid; the in-flight transaction is abandoned.

Decomposition:
- Shared package/header:
  - size encodings (SZ_B/H/W/D).
  - state encodings (ST_IDLE/REQ/WAIT/RESP).
  - TIMEOUT default.
- One combinational sub-module, lsu_lane_align: computes mem_wdata/mem_wmask from (addr[2:0], size, wdata) and resp_rdata from (addr[2:0], size, unsigned, rdata). Unit-tested on its own.
- FSM and counter stay in lsu_mem_ctrl.

Test Plan:
- Signed byte load: addr=0x80000005, size=B, unsigned=0, mem_rdata=0x0000_8000_0000_0000 → mem_addr=0x80000000, mem_wmask=0, resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_err=0.
- Unsigned half load: addr=0x80000006, size=H, unsigned=1, mem_rdata=0xBEEF_0000_0000_0000 → resp_rdata=0x0000_0000_0000_BEEF; same with unsigned=0 → 0xFFFF_FFFF_FFFF_BEEF.
- Word store: addr=0x80000004, size=W, wdata=0x1234_5678 → mem_wen=1, mem_wmask=8'hF0, mem_wdata=0x1234_5678_0000_0000, resp_rdata=0.
- Misaligned request: addr=0x80000002, size=D → no mem_valid ever asserted, resp_valid 1 cycle after acceptance, resp_err=1.
- Stalls: mem_ready held low 5 cycles then high, mem_rsp_valid after 3 more cycles; resp_ready low for 4 cycles → mem_* stable throughout REQ, resp_* stable until the handshake, req_ready stays 0 until IDLE.
- Timeout and reset: mem_rsp_valid never arrives → resp_err=1 exactly TIMEOUT cycles after entering WAIT. Separately, rst pulsed while in WAIT → next cycle IDLE, req_ready=1, mem_valid=0.
